// File: rtl/uart_dport_resp.sv
// uart_dport_resp: memory-mapped 8N1 UART responder on the core data port.
// Writes to DATA are serialised on tx_o; received bytes are queued in an RX FIFO popped by DATA reads.
`default_nettype none

module uart_dport_resp #(
  parameter logic [31:0] BASE_ADDR  = 32'h9200_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic [10:0] mem_d_req_tag_i,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [31:0] mem_d_data_rd_o,
  output logic [10:0] mem_d_resp_tag_o,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        intr_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [11:0]   OFF_DATA  = 12'h000;
  localparam logic [11:0]   OFF_STAT  = 12'h004;
  localparam logic [11:0]   OFF_CTRL  = 12'h008;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_meta, rx_sync, rx_armed, rx_push, rx_ferr_evt;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          rx_irq_en, overrun, frame_err;

  logic        is_wr, req, in_region, hit_data, hit_stat, hit_ctrl, bad;
  logic        tx_busy, tx_req, acc, wr_acc, rd_acc, send, pop, stat_clr;
  logic        fifo_empty, fifo_full, push_ok, overrun_evt;
  logic [31:0] rd_data;
  logic        unused_wdata;

  assign unused_wdata = ^mem_d_data_wr_i[31:8];

  assign is_wr     = |mem_d_wr_i;
  assign req       = mem_d_rd_i | is_wr;
  assign in_region = (mem_d_addr_i[31:12] == BASE_ADDR[31:12]);
  assign hit_data  = in_region && (mem_d_addr_i[11:0] == OFF_DATA);
  assign hit_stat  = in_region && (mem_d_addr_i[11:0] == OFF_STAT);
  assign hit_ctrl  = in_region && (mem_d_addr_i[11:0] == OFF_CTRL);
  assign bad       = !(hit_data || hit_stat || hit_ctrl);

  // Only a byte send into a busy transmitter stalls; everything else is taken at once.
  assign tx_busy        = (tx_state != TX_IDLE);
  assign tx_req         = req && is_wr && hit_data && mem_d_wr_i[0];
  assign mem_d_accept_o = !(tx_req && tx_busy);
  assign acc            = req && mem_d_accept_o;
  assign wr_acc         = acc && is_wr;
  assign rd_acc         = acc && !is_wr;
  assign send           = acc && tx_req;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop         = rd_acc && hit_data && !fifo_empty;
  assign stat_clr    = rd_acc && hit_stat;
  assign push_ok     = rx_push && (!fifo_full || pop);
  assign overrun_evt = rx_push && fifo_full && !pop;

  always_comb begin
    rd_data = 32'h0;
    if (rd_acc) begin
      if (hit_data && !fifo_empty)
        rd_data = {24'h0, fifo_mem[rd_ptr[AW-1:0]]};
      else if (hit_stat)
        rd_data = {27'h0, frame_err, overrun, tx_busy, fifo_full, !fifo_empty};
      else if (hit_ctrl)
        rd_data = {31'h0, rx_irq_en};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_d_ack_o      <= 1'b0;
      mem_d_error_o    <= 1'b0;
      mem_d_data_rd_o  <= 32'h0;
      mem_d_resp_tag_o <= 11'h0;
      rx_irq_en        <= 1'b0;
      overrun          <= 1'b0;
      frame_err        <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      intr_o           <= 1'b0;
    end else begin
      mem_d_ack_o     <= acc;
      mem_d_error_o   <= acc && bad;
      mem_d_data_rd_o <= rd_data;
      if (acc)
        mem_d_resp_tag_o <= mem_d_req_tag_i;
      if (wr_acc && hit_ctrl && mem_d_wr_i[0])
        rx_irq_en <= mem_d_data_wr_i[0];
      // A new event in the same cycle as the clearing read wins.
      overrun   <= (overrun && !stat_clr) || overrun_evt;
      frame_err <= (frame_err && !stat_clr) || rx_ferr_evt;
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      intr_o <= rx_irq_en && (!fifo_empty || overrun);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok)
      fifo_mem[wr_ptr[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h0;
      tx_o     <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: if (send) begin
          tx_state <= TX_START;
          tx_cnt   <= '0;
          tx_shift <= mem_d_data_wr_i[7:0];
          tx_o     <= 1'b0;
        end
        TX_START: if (tx_cnt == CNT_LAST) begin
          tx_cnt   <= '0;
          tx_bit   <= 3'd0;
          tx_o     <= tx_shift[0];
          tx_state <= TX_DATA;
        end else tx_cnt <= tx_cnt + CNT_ONE;
        TX_DATA: if (tx_cnt == CNT_LAST) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx_o     <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_o     <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt + CNT_ONE;
        TX_STOP: if (tx_cnt == CNT_LAST) begin
          tx_cnt   <= '0;
          tx_state <= TX_IDLE;
        end else tx_cnt <= tx_cnt + CNT_ONE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // rx_armed holds off start detection after a frame until the line has been seen high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= 3'd0;
      rx_shift    <= 8'h0;
      rx_armed    <= 1'b0;
      rx_push     <= 1'b0;
      rx_ferr_evt <= 1'b0;
    end else begin
      rx_meta     <= rx_i;
      rx_sync     <= rx_meta;
      rx_push     <= 1'b0;
      rx_ferr_evt <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_armed) begin
            if (rx_sync) rx_armed <= 1'b1;
          end else if (!rx_sync) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: if (rx_cnt == CNT_HALF) begin
          rx_cnt   <= '0;
          rx_bit   <= 3'd0;
          rx_state <= rx_sync ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + CNT_ONE;
        RX_DATA: if (rx_cnt == CNT_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_sync, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
          else rx_bit <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + CNT_ONE;
        RX_STOP: if (rx_cnt == CNT_LAST) begin
          rx_cnt      <= '0;
          rx_push     <= rx_sync;
          rx_ferr_evt <= !rx_sync;
          rx_armed    <= 1'b0;
          rx_state    <= RX_IDLE;
        end else rx_cnt <= rx_cnt + CNT_ONE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
